plru_array: RTL and testbench

PLRU_ARRAY -- requirements
Module: plru_array

---
 rtl/plru_array_pkg.sv | 54 +++++
 rtl/plru_array_if.sv | 32 +++
 rtl/plru_array_tree.sv | 42 ++++
 rtl/plru_array.sv | 85 ++++++++
 tb/tb_plru_array.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/plru_array_pkg.sv
// Shared cache package: PLRU FSM states and tree-PLRU helper functions.
// Helpers work on a 16-way maximum; callers pass their real way width.
package plru_array_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } plru_state_e;

  localparam int MAX_WAY_W = 4;
  localparam int MAX_NODES = 16;

  // Point every node on the root-to-leaf path toward the accessed way.
  function automatic logic [MAX_NODES-1:0] tree_update(
    input logic [MAX_NODES-1:0] bits,
    input logic [MAX_WAY_W-1:0] way,
    input int                   way_w
  );
    logic [MAX_NODES-1:0] nb;
    logic [3:0]           node;
    logic                 b;
    nb   = bits;
    node = '0;
    for (int l = MAX_WAY_W-1; l >= 0; l--) begin
      if (l < way_w) begin
        b        = way[2'(l)];
        nb[node] = b;
        node     = {node[2:0], 1'b0} + 4'd1 + {3'b0, b};
      end
    end
    return nb;
  endfunction

  // Descend away from the most recently used half at every level.
  function automatic logic [MAX_WAY_W-1:0] tree_victim(
    input logic [MAX_NODES-1:0] bits,
    input int                   way_w
  );
    logic [MAX_WAY_W-1:0] v;
    logic [3:0]           node;
    logic                 b;
    v    = '0;
    node = '0;
    for (int l = MAX_WAY_W-1; l >= 0; l--) begin
      if (l < way_w) begin
        b          = ~bits[node];
        v[2'(l)]   = b;
        node       = {node[2:0], 1'b0} + 4'd1 + {3'b0, b};
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/plru_array_if.sv
// Lookup / update / clear bundle between the tag pipeline and the PLRU array.
// Master drives requests; slave returns the victim and busy.
interface plru_array_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic             lkp_valid;
  logic [SET_W-1:0] lkp_set;
  logic [WAYS-1:0]  lkp_way_valid;
  logic             victim_valid;
  logic [WAY_W-1:0] victim_way;
  logic             upd_valid;
  logic [SET_W-1:0] upd_set;
  logic [WAY_W-1:0] upd_way;
  logic             clr_req;
  logic             busy;

  modport master (
    output lkp_valid, lkp_set, lkp_way_valid,
    output upd_valid, upd_set, upd_way, clr_req,
    input  victim_valid, victim_way, busy
  );

  modport slave (
    input  lkp_valid, lkp_set, lkp_way_valid,
    input  upd_valid, upd_set, upd_way, clr_req,
    output victim_valid, victim_way, busy
  );
endinterface

// File: rtl/plru_array_tree.sv
// Combinational tree-PLRU: next bits for an access and victim for a lookup.
// The update result also feeds the lookup side for same-set bypass.
module plru_tree
  import plru_array_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int WAY_W  = $clog2(WAYS),
  parameter int NODE_W = WAYS - 1
) (
  input  logic [NODE_W-1:0] i_upd_bits,
  input  logic [WAY_W-1:0]  i_upd_way,
  output logic [NODE_W-1:0] o_upd_bits,
  input  logic [NODE_W-1:0] i_lkp_bits,
  input  logic [WAYS-1:0]   i_lkp_mask,
  output logic [WAY_W-1:0]  o_victim
);

  logic [WAY_W-1:0] w_walk;
  logic [WAY_W-1:0] w_inv_way;
  logic             w_inv;

  assign o_upd_bits = NODE_W'(tree_update(
    16'(i_upd_bits), 4'(i_upd_way), WAY_W));

  assign w_walk = WAY_W'(tree_victim(
    16'(i_lkp_bits), WAY_W));

  // Downward scan leaves the lowest invalid way.
  always_comb begin
    w_inv     = 1'b0;
    w_inv_way = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      if (!i_lkp_mask[i]) begin
        w_inv     = 1'b1;
        w_inv_way = WAY_W'(i);
      end
    end
  end

  assign o_victim = w_inv ? w_inv_way : w_walk;

endmodule

// File: rtl/plru_array.sv
// Per-set tree-PLRU state in flops with one-cycle victim lookup,
// same-cycle update bypass and a one-set-per-cycle clear sweep.
module plru_array
  import plru_array_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  plru_array_if.slave  bus
);

  localparam int WAY_W  = $clog2(WAYS);
  localparam int SET_W  = $clog2(SETS);
  localparam int NODE_W = WAYS - 1;

  logic [NODE_W-1:0] r_tree [SETS];
  plru_state_e       r_state;
  logic [SET_W-1:0]  r_cnt;
  logic              r_victim_valid;
  logic [WAY_W-1:0]  r_victim_way;

  logic [NODE_W-1:0] w_upd_bits;
  logic [NODE_W-1:0] w_next_bits;
  logic [NODE_W-1:0] w_lkp_bits;
  logic [WAY_W-1:0]  w_victim;
  logic              w_bypass;

  assign w_upd_bits = r_tree[bus.upd_set];
  assign w_bypass   = bus.upd_valid
                    && (bus.upd_set == bus.lkp_set);
  assign w_lkp_bits = w_bypass ? w_next_bits
                               : r_tree[bus.lkp_set];

  plru_tree #(
    .WAYS (WAYS)
  ) u_tree (
    .i_upd_bits (w_upd_bits),
    .i_upd_way  (bus.upd_way),
    .o_upd_bits (w_next_bits),
    .i_lkp_bits (w_lkp_bits),
    .i_lkp_mask (bus.lkp_way_valid),
    .o_victim   (w_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) r_tree[s] <= '0;
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_victim_valid <= 1'b0;
      r_victim_way   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.clr_req) begin
            r_state        <= S_CLEAR;
            r_cnt          <= '0;
            r_victim_valid <= 1'b0;
          end else begin
            if (bus.upd_valid)
              r_tree[bus.upd_set] <= w_next_bits;
            r_victim_valid <= bus.lkp_valid;
            if (bus.lkp_valid)
              r_victim_way <= w_victim;
          end
        end
        S_CLEAR: begin
          r_tree[r_cnt]  <= '0;
          r_victim_valid <= 1'b0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == SET_W'(SETS-1))
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state == S_CLEAR);
  assign bus.victim_valid = r_victim_valid;
  assign bus.victim_way   = r_victim_way;

endmodule

// File: tb/tb_plru_array.sv
// Scoreboard bench for plru_array: directed cases plus random traffic
// against a recency-timestamp model of tree-PLRU.
module tb_plru_array;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);

  logic clk;
  logic rst_n;

  plru_array_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

  plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec;
  int          n_err;
  int          expq[$];
  int unsigned ts[SETS][WAYS];
  int unsigned tstamp;
  int          clr_left;

  task automatic check(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int unsigned max_ts(int s, int lo, int n);
    int unsigned m;
    m = 0;
    for (int i = lo; i < lo + n; i++)
      if (ts[s][i] > m) m = ts[s][i];
    return m;
  endfunction

  // Each tree node follows the most recent access inside its subtree;
  // victim side is the half whose latest access is older.
  function automatic int model_victim(int s, logic [WAYS-1:0] m);
    int lo, sz, half;
    for (int i = 0; i < WAYS; i++)
      if (!m[i]) return i;
    lo = 0;
    sz = WAYS;
    while (sz > 1) begin
      half = sz / 2;
      if (!(max_ts(s, lo + half, half) > max_ts(s, lo, half)))
        lo = lo + half;
      sz = half;
    end
    return lo;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) ts[s][w] = 0;
  endtask

  task automatic cycle(input bit lv, input int ls,
                       input logic [WAYS-1:0] lm,
                       input bit uv, input int us, input int uw,
                       input bit cr, input int xp = -1);
    @(posedge clk);
    #1;
    check("busy", int'(bus.busy), int'(clr_left > 0));
    bus.lkp_valid     = lv;
    bus.lkp_set       = SET_W'(ls);
    bus.lkp_way_valid = lm;
    bus.upd_valid     = uv;
    bus.upd_set       = SET_W'(us);
    bus.upd_way       = WAY_W'(uw);
    bus.clr_req       = cr;
    if (clr_left > 0) begin
      clr_left--;
    end else if (cr) begin
      clr_left = SETS;
      model_clear();
    end else begin
      if (uv) begin
        tstamp++;
        ts[us][uw] = tstamp;
      end
      if (lv) expq.push_back(xp >= 0 ? xp : model_victim(ls, lm));
    end
  endtask

  task automatic idle();
    cycle(0, 0, '1, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    int e;
    if (rst_n && bus.victim_valid) begin
      if (expq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = expq.pop_front();
        check("victim_way", int'(bus.victim_way), e);
      end
    end
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    tstamp   = 0;
    clr_left = 0;
    model_clear();
    rst_n             = 1'b0;
    bus.lkp_valid     = 1'b0;
    bus.lkp_set       = '0;
    bus.lkp_way_valid = '1;
    bus.upd_valid     = 1'b0;
    bus.upd_set       = '0;
    bus.upd_way       = '0;
    bus.clr_req       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_victim_valid", int'(bus.victim_valid), 0);
    check("rst_victim_way", int'(bus.victim_way), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // Fresh set walks to the top way.
    cycle(1, 5, 4'b1111, 0, 0, 0, 0, 3);
    // Ways 0..3 touched in order leave way 0 as PLRU.
    for (int w = 0; w < 4; w++) cycle(0, 0, '1, 1, 2, w, 0);
    cycle(1, 2, 4'b1111, 0, 0, 0, 0, 0);
    cycle(1, 3, 4'b1111, 0, 0, 0, 0, 3);
    // Invalid way overrides the tree.
    cycle(1, 9, 4'b1011, 0, 0, 0, 0, 2);
    // Same-cycle update is bypassed into the lookup.
    cycle(1, 7, 4'b1111, 1, 7, 3, 0, 1);
    cycle(1, 7, 4'b1111, 0, 0, 0, 0, 1);

    // Clear sweep: requests during busy are ignored.
    cycle(0, 0, '1, 0, 0, 0, 1);
    for (int i = 0; i < SETS; i++) cycle(1, i, '1, 1, i, 0, 0);
    for (int s = 0; s < SETS; s++) cycle(1, s, 4'b1111, 0, 0, 0, 0, 3);

    // Reset in the middle of a sweep.
    for (int w = 0; w < 4; w++) cycle(0, 0, '1, 1, 4, w, 0);
    cycle(0, 0, '1, 0, 0, 0, 1);
    repeat (4) idle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midclr_rst_busy", int'(bus.busy), 0);
    check("midclr_rst_valid", int'(bus.victim_valid), 0);
    clr_left = 0;
    model_clear();
    expq.delete();
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < SETS; s++) cycle(1, s, 4'b1111, 0, 0, 0, 0, 3);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int ls, us;
      logic [WAYS-1:0] m;
      ls = $urandom_range(0, SETS-1);
      us = ($urandom_range(0, 1) == 1) ? ls : $urandom_range(0, SETS-1);
      m  = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
      cycle($urandom_range(0, 1) == 1, ls, m,
            $urandom_range(0, 2) != 0, us, $urandom_range(0, WAYS-1),
            $urandom_range(0, 199) == 0);
    end

    while (clr_left > 0) idle();
    repeat (3) idle();
    check("queue_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
